window_allocator: RTL

- Receiving end of the position-issue interface: one instance per bit of the issuer's one-hot allocator select.
- Latches an issued window center, snoops the broadcast pixel stream, and captures the KERNEL_DIM x KERNEL_DIM neighbourhood; out-of-image taps are zero-filled.
- Presents the completed window to the convolution datapath over a valid/ready handshake, then returns to idle for the next issue.

---
 rtl/window_allocator.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/window_allocator.sv
// window_allocator: one receiving slot of the position-issue interface.
// Latches an issued window center, snoops the broadcast pixel stream and
// assembles a KERNEL_DIM x KERNEL_DIM neighbourhood. Taps that fall outside
// the real image are zero-filled at issue time. The finished window is
// offered over a valid/ready handshake.
// Optional build macro: WINDOW_ALLOCATOR_STATS_EN adds o_win_count and
// o_dup_count statistics outputs.
module window_allocator #(
   parameter int unsigned KERNEL_DIM  = 3,
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst_n,
   input  logic                                          i_select,
   input  logic [7:0]                                    i_center_x,
   input  logic [7:0]                                    i_center_y,
   input  logic [7:0]                                    i_image_dim,
   input  logic [1:0]                                    i_padding,
   input  logic                                          i_pix_valid,
   input  logic [7:0]                                    i_pix_x,
   input  logic [7:0]                                    i_pix_y,
   input  logic [PIXEL_WIDTH-1:0]                        i_pix_data,
   output logic                                          o_win_valid,
   input  logic                                          i_win_ready,
   output logic [KERNEL_DIM*KERNEL_DIM*PIXEL_WIDTH-1:0]  o_win_data,
   output logic                                          o_busy,
   output logic                                          o_issue_overrun
`ifdef WINDOW_ALLOCATOR_STATS_EN
   ,
   output logic [15:0]                                   o_win_count,
   output logic [7:0]                                    o_dup_count
`endif
);

   localparam int unsigned KK = KERNEL_DIM * KERNEL_DIM;
   localparam int unsigned H  = (KERNEL_DIM - 1) / 2;
   localparam int unsigned CW = $clog2(KK + 1);
   localparam int unsigned DW = KK * PIXEL_WIDTH;
   localparam logic signed [9:0] HS = 10'(H);

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StFull
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [7:0]            r_cx;
   logic [7:0]            r_cy;
   logic [KK-1:0]         r_mask;
   logic [CW-1:0]         r_count;
   logic [DW-1:0]         r_data;
   logic                  r_overrun;

   logic signed [9:0]     w_lo;
   logic signed [9:0]     w_hi;
   logic [KK-1:0]         w_pre_mask;
   logic [CW-1:0]         w_pre_count;

   logic signed [9:0]     w_dx;
   logic signed [9:0]     w_dy;
   logic                  w_armed_pix;
   logic [KK-1:0]         w_hit_oh;
   logic [KK-1:0]         w_cap_oh;
   logic                  w_cap;
   logic                  w_dup;

   logic                  w_xfer;
   logic                  w_arm;

   // Handshake and issue-acceptance decode
   always_comb begin
      w_xfer = (r_state == StFull) && i_win_ready;
      // An issue is accepted when idle, or on the very edge the held window leaves
      w_arm  = i_select && ((r_state == StIdle) || w_xfer);
   end

   // Pre-fill: taps whose padded coordinate lies outside the real image
   always_comb begin : p_prefill
      logic signed [9:0] v_row;
      logic signed [9:0] v_col;
      w_pre_mask  = '0;
      w_pre_count = '0;
      v_row       = '0;
      v_col       = '0;
      w_lo        = $signed({8'b0, i_padding});
      w_hi        = $signed({2'b00, i_image_dim}) + w_lo - 10'sd1;
      for (int r = 0; r < int'(KERNEL_DIM); r++) begin
         for (int c = 0; c < int'(KERNEL_DIM); c++) begin
            // 10-bit signed so a center near 0 or 255 cannot wrap into range
            v_row = $signed({2'b00, i_center_y}) - HS + $signed(10'(r));
            v_col = $signed({2'b00, i_center_x}) - HS + $signed(10'(c));
            if ((v_row < w_lo) || (v_row > w_hi) || (v_col < w_lo) || (v_col > w_hi)) begin
               w_pre_mask[r*KERNEL_DIM+c] = 1'b1;
               w_pre_count                = w_pre_count + CW'(1);
            end
         end
      end
   end

   // Snoop: locate the incoming pixel within the armed window
   always_comb begin
      w_armed_pix = (r_state == StArmed) && i_pix_valid;
      // Offsets from the window's top-left corner; negative means outside
      w_dx        = $signed({2'b00, i_pix_x}) - ($signed({2'b00, r_cx}) - HS);
      w_dy        = $signed({2'b00, i_pix_y}) - ($signed({2'b00, r_cy}) - HS);
      w_hit_oh    = '0;
      for (int r = 0; r < int'(KERNEL_DIM); r++) begin
         for (int c = 0; c < int'(KERNEL_DIM); c++) begin
            w_hit_oh[r*KERNEL_DIM+c] = w_armed_pix &&
                                       (w_dx == $signed(10'(c))) &&
                                       (w_dy == $signed(10'(r)));
         end
      end
      w_cap_oh = w_hit_oh & ~r_mask;
      w_cap    = |w_cap_oh;
      w_dup    = |(w_hit_oh & r_mask);
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_select) begin
               w_state_nxt = StArmed;
            end
         end
         StArmed: begin
            // Also covers a window completed entirely by the pre-fill
            if (r_count == CW'(KK)) begin
               w_state_nxt = StFull;
            end
         end
         StFull: begin
            if (i_win_ready) begin
               w_state_nxt = i_select ? StArmed : StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Outputs decoded from state and held window registers
   always_comb begin
      o_win_valid     = (r_state == StFull);
      o_busy          = (r_state != StIdle);
      o_win_data      = r_data;
      o_issue_overrun = r_overrun;
   end

   // Window datapath: arm, capture, clear on transfer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cx    <= '0;
         r_cy    <= '0;
         r_mask  <= '0;
         r_count <= '0;
         r_data  <= '0;
      end else if (w_arm) begin
         r_cx    <= i_center_x;
         r_cy    <= i_center_y;
         r_mask  <= w_pre_mask;
         r_count <= w_pre_count;
         // Clearing every tap zero-fills the off-image slots in one step
         r_data  <= '0;
      end else if (w_xfer) begin
         r_mask  <= '0;
         r_count <= '0;
      end else if (w_cap) begin
         r_mask  <= r_mask | w_cap_oh;
         r_count <= r_count + CW'(1);
         for (int s = 0; s < int'(KK); s++) begin
            if (w_cap_oh[s]) begin
               r_data[s*PIXEL_WIDTH +: PIXEL_WIDTH] <= i_pix_data;
            end
         end
      end
   end

   // Sticky flag for issues that arrive while a window is in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overrun <= 1'b0;
      end else if (i_select && !w_arm) begin
         r_overrun <= 1'b1;
      end
   end

`ifdef WINDOW_ALLOCATOR_STATS_EN
   logic [15:0] r_win_count;
   logic [7:0]  r_dup_count;

   // Transfer counter wraps; duplicate counter saturates
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_win_count <= '0;
         r_dup_count <= '0;
      end else begin
         if (w_xfer) begin
            r_win_count <= r_win_count + 16'd1;
         end
         if (w_dup && (r_dup_count != 8'hFF)) begin
            r_dup_count <= r_dup_count + 8'd1;
         end
      end
   end

   // Statistics outputs
   always_comb begin
      o_win_count = r_win_count;
      o_dup_count = r_dup_count;
   end
`endif

endmodule
